// File: rtl/alu_result_buffer_if.sv
// Handshake bundle between the ALU result path, the result buffer and the
// write-back/display consumer.
interface alu_result_buffer_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] fout;
  logic             Cin;
  logic [3:0]       Op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] res;
  logic [3:0]       res_op;
  logic [3:0]       flags;

  // Buffer side: accepts ALU results, presents the head entry.
  modport slave (
    input  in_valid, fout, Cin, Op, out_ready,
    output in_ready, out_valid, res, res_op, flags
  );

  // Producer/consumer side.
  modport master (
    output in_valid, fout, Cin, Op, out_ready,
    input  in_ready, out_valid, res, res_op, flags
  );
endinterface

// File: rtl/alu_result_buffer.sv
// Small FIFO that tags each ALU result with {Z,N,C,P} flags and its opcode,
// decoupling the single-cycle ALU from a write-back stage that may stall.
module alu_result_buffer #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  alu_result_buffer_if.slave       bus,
  output logic [$clog2(DEPTH):0]   count,
  output logic [CNT_W-1:0]         stall_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_res   [DEPTH];
  logic [3:0]       mem_op    [DEPTH];
  logic [3:0]       mem_flags [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;
  logic [3:0]       new_flags;

  // Readiness depends only on registered occupancy, so a pop never opens a
  // push slot in the same cycle when full.
  assign bus.in_ready  = (count != FULL_COUNT);
  assign bus.out_valid = (count != '0);

  assign push = bus.in_valid  && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  // Carry passes straight through: shifter fill and adder carry share Cin.
  assign new_flags = {(bus.fout == '0), bus.fout[WIDTH-1], bus.Cin, ^bus.fout};

  assign bus.res    = mem_res[rd_ptr];
  assign bus.res_op = mem_op[rd_ptr];
  assign bus.flags  = mem_flags[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_res[i]   <= '0;
        mem_op[i]    <= '0;
        mem_flags[i] <= '0;
      end
    end else if (push) begin
      mem_res[wr_ptr]   <= bus.fout;
      mem_op[wr_ptr]    <= bus.Op;
      mem_flags[wr_ptr] <= new_flags;
    end
  end

  // Pointers wrap naturally; full/empty come from count alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (bus.in_valid && !bus.in_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_result_buffer.sv
// Randomized and directed bench for alu_result_buffer against a queue-based
// reference model of the tagged result FIFO.
module tb_alu_result_buffer;

  localparam int WIDTH = 4;
  localparam int DEPTH = 2;
  localparam int CNT_W = 8;
  localparam int STALL_MAX = (1 << CNT_W) - 1;

  typedef struct {
    logic [3:0] res;
    logic [3:0] op;
    logic [3:0] flags;
  } entry_t;

  logic clk;
  logic rst;
  logic [$clog2(DEPTH):0] count;
  logic [CNT_W-1:0]       stall_cnt;

  alu_result_buffer_if #(.WIDTH(WIDTH)) bus ();

  alu_result_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .count     (count),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     assertions = 0;
  int     failures   = 0;
  entry_t model_q[$];
  int     model_stall = 0;

  function automatic logic [3:0] expected_flags(input int f, input int c);
    int z, n, p;
    z = (f == 0) ? 1 : 0;
    n = (f >= (1 << (WIDTH - 1))) ? 1 : 0;
    p = $countones(f) % 2;
    return 4'((z << 3) | (n << 2) | ((c & 1) << 1) | p);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertions++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Compare all visible state against the model; called away from the clock edge.
  task automatic checkState(input string tag);
    checkOutput({tag, ".out_valid"}, 32'(bus.out_valid), 32'(model_q.size() != 0));
    checkOutput({tag, ".in_ready"},  32'(bus.in_ready),  32'(model_q.size() != DEPTH));
    checkOutput({tag, ".count"},     32'(count),         32'(model_q.size()));
    checkOutput({tag, ".stall_cnt"}, 32'(stall_cnt),     32'(model_stall));
    if (model_q.size() != 0) begin
      checkOutput({tag, ".res"},    32'(bus.res),    32'(model_q[0].res));
      checkOutput({tag, ".res_op"}, 32'(bus.res_op), 32'(model_q[0].op));
      checkOutput({tag, ".flags"},  32'(bus.flags),  32'(model_q[0].flags));
    end
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then check.
  task automatic applyStimulus(input string tag, input logic v, input logic [3:0] f,
                               input logic c, input logic [3:0] o, input logic r);
    bit do_push, do_pop;
    entry_t e;
    bus.in_valid  = v;
    bus.fout      = f;
    bus.Cin       = c;
    bus.Op        = o;
    bus.out_ready = r;
    do_push = v && (model_q.size() < DEPTH);
    do_pop  = r && (model_q.size() > 0);
    if (v && !do_push && model_stall < STALL_MAX) model_stall++;
    @(posedge clk);
    if (do_pop) void'(model_q.pop_front());
    if (do_push) begin
      e.res   = f;
      e.op    = o;
      e.flags = expected_flags(int'(f), int'(c));
      model_q.push_back(e);
    end
    @(negedge clk);
    checkState(tag);
  endtask

  task automatic doReset();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.fout      = '0;
    bus.Cin       = 1'b0;
    bus.Op        = '0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_q.delete();
    model_stall = 0;
  endtask

  initial begin
    logic       v, r, c;
    logic [3:0] f, o;

    rst = 1'b1;
    doReset();

    // Reset state, including zeroed head contents.
    checkState("reset");
    checkOutput("reset.res",    32'(bus.res),    32'h0);
    checkOutput("reset.res_op", 32'(bus.res_op), 32'h0);
    checkOutput("reset.flags",  32'(bus.flags),  32'h0);
    applyStimulus("idle", 1'b0, 4'h0, 1'b0, 4'h0, 1'b0);

    // Zero result with carry set.
    applyStimulus("push_zero", 1'b1, 4'b0000, 1'b1, 4'b0101, 1'b0);
    checkOutput("push_zero.flags_const", 32'(bus.flags), 32'b1010);

    // Fill, then stall three cycles.
    doReset();
    applyStimulus("fill0", 1'b1, 4'b1000, 1'b0, 4'h1, 1'b0);
    applyStimulus("fill1", 1'b1, 4'b0111, 1'b1, 4'h2, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus("stall", 1'b1, 4'b1111, 1'b0, 4'h3, 1'b0);
    checkOutput("stall3.stall_cnt", 32'(stall_cnt), 32'd3);
    checkOutput("stall3.head_flags", 32'(bus.flags), 32'b0101);

    // Single pop, then push/pop every cycle across pointer wrap.
    applyStimulus("pop1", 1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
    checkOutput("pop1.in_ready", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < 10; i++)
      applyStimulus("stream", 1'b1, 4'(i + 1), 1'(i), 4'(i), 1'b1);
    checkOutput("stream.count", 32'(count), 32'd1);

    // Asynchronous reset mid-cycle with two stored entries.
    doReset();
    applyStimulus("ar_fill0", 1'b1, 4'h9, 1'b1, 4'h4, 1'b0);
    applyStimulus("ar_fill1", 1'b1, 4'h6, 1'b0, 4'h5, 1'b0);
    bus.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst.out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("async_rst.count",     32'(count),         32'd0);
    checkOutput("async_rst.in_ready",  32'(bus.in_ready),  32'd1);
    model_q.delete();
    model_stall = 0;
    @(negedge clk);
    rst = 1'b0;
    applyStimulus("ar_push_a", 1'b1, 4'hA, 1'b0, 4'h6, 1'b0);
    applyStimulus("ar_push_b", 1'b1, 4'h3, 1'b1, 4'h7, 1'b0);
    checkOutput("ar_first.res", 32'(bus.res), 32'hA);
    applyStimulus("ar_pop_a", 1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
    applyStimulus("ar_pop_b", 1'b0, 4'h0, 1'b0, 4'h0, 1'b1);

    // Stall counter saturation.
    doReset();
    applyStimulus("sat_fill0", 1'b1, 4'h1, 1'b0, 4'h0, 1'b0);
    applyStimulus("sat_fill1", 1'b1, 4'h2, 1'b0, 4'h0, 1'b0);
    for (int i = 0; i < 300; i++) applyStimulus("sat", 1'b1, 4'h5, 1'b1, 4'h8, 1'b0);
    checkOutput("sat.stall_cnt", 32'(stall_cnt), 32'(STALL_MAX));

    // Random traffic; inputs are held while stalled as upstream must.
    doReset();
    v = 1'b0; f = '0; c = 1'b0; o = '0;
    for (int i = 0; i < 400; i++) begin
      if (!(v && !bus.in_ready)) begin
        v = 1'($urandom_range(0, 3) != 0);
        f = 4'($urandom);
        c = 1'($urandom);
        o = 4'($urandom);
      end
      r = 1'($urandom_range(0, 2) != 0);
      applyStimulus("rand", v, f, c, o, r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
